uart_rx_checked: RTL

Frame receiver with midpoint majority-vote sampling, optional parity, per-frame error flags, break detection and an overrun-protected holding register. It is the receive-side counterpart of the UART transmitter and accepts the frame format the transmitter produces (start bit, LSB-first data, optional parity, `NB_STOP` stop bits). The host side uses the same `o_rdy`/`i_re` pop handshake as the `uart` top level. It is intended to replace the plain receive path wherever line noise or error reporting matters.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_bit_sampler.sv | 41 ++++
 rtl/uart_rx_checked.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM states and parity mode encodings
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;
endpackage

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: two-flop synchronizer, free-running bit timer and mid-bit 2-of-3 vote
//   clk, rst   : clock, synchronous active-high reset
//   rx         : raw serial line
//   clr        : restart the bit timer at 0
//   rx_s       : synchronized line
//   tick       : one-cycle strobe, rx_bit is valid
//   rx_bit     : majority of the three mid-bit samples
module uart_bit_sampler #(
    parameter int CLK_SIZE  = 434,
    parameter int WIDTH_CLK = $clog2(CLK_SIZE)
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic clr,
    output logic rx_s,
    output logic tick,
    output logic rx_bit
);
    localparam int HALF = CLK_SIZE / 2;
    logic                 sync1, s0, s1;
    logic [WIDTH_CLK-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            s0    <= 1'b1;
            s1    <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            cnt   <= (clr || cnt == WIDTH_CLK'(CLK_SIZE - 1)) ? '0 : cnt + 1'b1;
            if (cnt == WIDTH_CLK'(HALF - 1)) s0 <= rx_s;
            if (cnt == WIDTH_CLK'(HALF)) s1 <= rx_s;
        end
    end
    // third sample is the live rx_s, so the vote resolves in the HALF+1 cycle
    assign tick   = cnt == WIDTH_CLK'(HALF + 1);
    assign rx_bit = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
endmodule

// File: rtl/uart_rx_checked.sv
// uart_rx_checked: UART frame receiver with parity/framing flags, break detect and overrun-safe holding register
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_rx         : serial line (idle high)
//   i_re         : pop the held frame
//   o_data       : held data; o_rdy valid; o_perr/o_ferr its error flags
//   o_ovr        : sticky, a frame was dropped while o_rdy was high
//   o_brk        : line is in break
module uart_rx_checked
    import uart_pkg::*;
#(
    parameter int WIDTH_DATA = 8,
    parameter int NB_STOP    = 2,
    parameter int PARITY     = 0,
    parameter int CLK_SIZE   = 434,
    parameter int WIDTH_CLK  = $clog2(CLK_SIZE)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    input  logic                  i_re,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_rdy,
    output logic                  o_perr,
    output logic                  o_ferr,
    output logic                  o_ovr,
    output logic                  o_brk
);
    localparam int IW = $clog2(WIDTH_DATA + NB_STOP);
    state_t                state, state_n;
    logic                  rx_s, tick, rx_bit, clr, last, brk_now;
    logic [WIDTH_DATA-1:0] sh;
    logic [IW-1:0]         idx;
    logic                  par_acc, nz, perr, ferr;
    uart_bit_sampler #(.CLK_SIZE(CLK_SIZE), .WIDTH_CLK(WIDTH_CLK)) u_smp (
        .clk(i_clk), .rst(i_rst), .rx(i_rx), .clr(clr),
        .rx_s(rx_s), .tick(tick), .rx_bit(rx_bit)
    );
    // nz tracks any 1 after the start bit; with the final stop also 0 the frame is a break
    assign brk_now = ~nz & ~rx_bit;
    always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        clr     = 1'b0;
        last    = 1'b0;
        unique case (state)
            IDLE:  if (!rx_s) begin
                state_n = START;
                clr     = 1'b1;
            end
            START: if (tick) state_n = rx_bit ? IDLE : DATA;
            DATA:  if (tick && idx == IW'(WIDTH_DATA - 1)) state_n = (PARITY != PAR_NONE) ? PAR : STOP;
            PAR:   if (tick) state_n = STOP;
            STOP:  if (tick && idx == IW'(NB_STOP - 1)) begin
                state_n = brk_now ? BREAK : IDLE;
                last    = 1'b1;
            end
            BREAK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sh      <= '0;
            idx     <= '0;
            par_acc <= 1'b0;
            nz      <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            o_data  <= '0;
            o_rdy   <= 1'b0;
            o_perr  <= 1'b0;
            o_ferr  <= 1'b0;
            o_ovr   <= 1'b0;
            o_brk   <= 1'b0;
        end else begin
            if (state == START) begin
                idx     <= '0;
                par_acc <= 1'b0;
                nz      <= 1'b0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
            end
            if (tick && state == DATA) begin
                sh      <= {rx_bit, sh[WIDTH_DATA-1:1]};
                par_acc <= par_acc ^ rx_bit;
                nz      <= nz | rx_bit;
                idx     <= (idx == IW'(WIDTH_DATA - 1)) ? '0 : idx + 1'b1;
            end
            if (tick && state == PAR) begin
                perr <= (PARITY == PAR_ODD) ? ~(par_acc ^ rx_bit) : (PARITY == PAR_EVEN) && (par_acc ^ rx_bit);
                nz   <= nz | rx_bit;
            end
            if (tick && state == STOP) begin
                idx  <= idx + 1'b1;
                ferr <= ferr | ~rx_bit;
                nz   <= nz | rx_bit;
            end
            // a pop on the completion edge frees the register, so the new frame lands and overrun clears
            if (last && !brk_now) begin
                if (!o_rdy || i_re) begin
                    o_data <= sh;
                    o_perr <= perr;
                    o_ferr <= ferr | ~rx_bit;
                    o_rdy  <= 1'b1;
                    o_ovr  <= 1'b0;
                end else begin
                    o_ovr <= 1'b1;
                end
            end else if (i_re && o_rdy) begin
                o_rdy <= 1'b0;
                o_ovr <= 1'b0;
            end
            if (last && brk_now) o_brk <= 1'b1;
            else if (state == BREAK && rx_s) o_brk <= 1'b0;
        end
    end
endmodule
